// File: rtl/quad_spike_encoder.sv
// Quadrature-to-spike front end: two encoders drive four leaky
// integrate-and-fire channels with clean pulse/refractory timing.
module quad_spike_encoder #(
  parameter int PULSE_LEN   = 2,
  parameter int REFRACT_LEN = 2,
  parameter int POT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enc_x_a,
  input  logic             enc_x_b,
  input  logic             enc_y_a,
  input  logic             enc_y_b,
  input  logic             cfg_enable,
  input  logic [POT_W-1:0] cfg_threshold,
  input  logic [7:0]       cfg_leak_period,
  input  logic             err_clr,
  output logic [3:0]       spike_out,
  output logic             enc_error,
  output logic [POT_W-1:0] pot_east,
  output logic [POT_W-1:0] pot_north,
  output logic [POT_W-1:0] pot_west,
  output logic [POT_W-1:0] pot_south
);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    REFR
  } ch_state_t;

  logic [1:0] sx1, sx2, px;
  logic [1:0] sy1, sy2, py;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sx1 <= 2'b00;
      sx2 <= 2'b00;
      px  <= 2'b00;
      sy1 <= 2'b00;
      sy2 <= 2'b00;
      py  <= 2'b00;
    end else begin
      sx1 <= {enc_x_a, enc_x_b};
      sx2 <= sx1;
      px  <= sx2;
      sy1 <= {enc_y_a, enc_y_b};
      sy2 <= sy1;
      py  <= sy2;
    end
  end

  // Gray position: 00->0, 01->1, 11->2, 10->3
  function automatic logic [1:0] gpos(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  logic [1:0] cxp, pxp, cyp, pyp;
  logic       x_fwd, x_bwd, x_ill;
  logic       y_fwd, y_bwd, y_ill;

  assign cxp   = gpos(sx2);
  assign pxp   = gpos(px);
  assign cyp   = gpos(sy2);
  assign pyp   = gpos(py);
  assign x_fwd = (cxp == 2'(pxp + 2'd1));
  assign x_bwd = (cxp == 2'(pxp - 2'd1));
  assign x_ill = ((sx2 ^ px) == 2'b11);
  assign y_fwd = (cyp == 2'(pyp + 2'd1));
  assign y_bwd = (cyp == 2'(pyp - 2'd1));
  assign y_ill = ((sy2 ^ py) == 2'b11);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_error <= 1'b0;
    end else if (x_ill || y_ill) begin
      enc_error <= 1'b1;
    end else if (err_clr) begin
      enc_error <= 1'b0;
    end
  end

  logic [7:0] leak_cnt;
  logic       leak_tick;

  // >= keeps a shortened period from running past its compare
  assign leak_tick = cfg_enable
                   && (cfg_leak_period != 8'd0)
                   && (leak_cnt >= cfg_leak_period - 8'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leak_cnt <= 8'd0;
    end else if (cfg_leak_period == 8'd0) begin
      leak_cnt <= 8'd0;
    end else if (cfg_enable) begin
      leak_cnt <= leak_tick ? 8'd0 : leak_cnt + 8'd1;
    end
  end

  logic [POT_W-1:0] thr_eff;
  logic [3:0]       inc;
  logic [3:0]       spk_vec;
  logic [POT_W-1:0] pot_arr [4];

  assign thr_eff = (cfg_threshold == '0) ? POT_W'(1) : cfg_threshold;
  assign inc     = cfg_enable ? {y_bwd, x_bwd, y_fwd, x_fwd} : 4'b0000;

  for (genvar g = 0; g < 4; g++) begin : g_ch
    ch_state_t        st;
    logic [7:0]       cnt;
    logic [POT_W-1:0] pot;
    logic             spk;
    logic [POT_W:0]   sum;
    logic [POT_W-1:0] p1, p2;
    logic             fire;

    assign sum  = {1'b0, pot} + (POT_W+1)'(inc[g]);
    assign p1   = sum[POT_W] ? '1 : sum[POT_W-1:0];
    assign p2   = (leak_tick && p1 != '0) ? p1 - POT_W'(1) : p1;
    assign fire = cfg_enable && (st == IDLE) && (p2 >= thr_eff);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st  <= IDLE;
        cnt <= 8'd0;
        pot <= '0;
        spk <= 1'b0;
      end else begin
        pot <= (!cfg_enable || fire) ? '0 : p2;
        unique case (st)
          IDLE: begin
            if (fire) begin
              st  <= HIGH;
              cnt <= 8'd0;
              spk <= 1'b1;
            end
          end
          HIGH: begin
            if (cnt == 8'(PULSE_LEN - 1)) begin
              st  <= REFR;
              cnt <= 8'd0;
              spk <= 1'b0;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          REFR: begin
            if (cnt == 8'(REFRACT_LEN - 1)) begin
              st  <= IDLE;
              cnt <= 8'd0;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          default: begin
            st  <= IDLE;
            cnt <= 8'd0;
            spk <= 1'b0;
          end
        endcase
      end
    end

    assign spk_vec[g] = spk;
    assign pot_arr[g] = pot;
  end

  assign spike_out = spk_vec;
  assign pot_east  = pot_arr[0];
  assign pot_north = pot_arr[1];
  assign pot_west  = pot_arr[2];
  assign pot_south = pot_arr[3];

endmodule

// File: tb/tb_quad_spike_encoder.sv
// Directed bench for quad_spike_encoder: latency, threshold, leak,
// error flag, refractory spacing, enable gating and async reset.
module tb_quad_spike_encoder;

  logic       clk;
  logic       rst_n;
  logic       enc_x_a, enc_x_b;
  logic       enc_y_a, enc_y_b;
  logic       cfg_enable;
  logic [7:0] cfg_threshold;
  logic [7:0] cfg_leak_period;
  logic       err_clr;
  logic [3:0] spike_out;
  logic       enc_error;
  logic [7:0] pot_east, pot_north, pot_west, pot_south;

  int checks = 0;
  int errors = 0;
  logic [1:0] xpos = 2'd0;
  logic [1:0] ypos = 2'd0;

  quad_spike_encoder #(
    .PULSE_LEN(2),
    .REFRACT_LEN(2),
    .POT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enc_x_a(enc_x_a),
    .enc_x_b(enc_x_b),
    .enc_y_a(enc_y_a),
    .enc_y_b(enc_y_b),
    .cfg_enable(cfg_enable),
    .cfg_threshold(cfg_threshold),
    .cfg_leak_period(cfg_leak_period),
    .err_clr(err_clr),
    .spike_out(spike_out),
    .enc_error(enc_error),
    .pot_east(pot_east),
    .pot_north(pot_north),
    .pot_west(pot_west),
    .pot_south(pot_south)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] gray(input logic [1:0] p);
    return {p[1], p[1] ^ p[0]};
  endfunction

  task automatic x_step(input bit fwd);
    xpos = fwd ? xpos + 2'd1 : xpos - 2'd1;
    {enc_x_a, enc_x_b} = gray(xpos);
  endtask

  task automatic y_step(input bit fwd);
    ypos = fwd ? ypos + 2'd1 : ypos - 2'd1;
    {enc_y_a, enc_y_b} = gray(ypos);
  endtask

  initial begin
    logic s, prev_s, seen;
    int hi, lo, pulses;

    rst_n = 1'b0;
    {enc_x_a, enc_x_b, enc_y_a, enc_y_b} = 4'b0000;
    cfg_enable = 1'b1;
    cfg_threshold = 8'd1;
    cfg_leak_period = 8'd0;
    err_clr = 1'b0;
    #23;
    chk("rst_spike", spike_out, 4'b0000);
    chk("rst_err", enc_error, 1'b0);
    chk("rst_pots", {pot_east, pot_north, pot_west, pot_south}, 32'd0);
    rst_n = 1'b1;
    ticks(2);

    // single forward X step, threshold 1
    x_step(1);
    tick(); chk("lat_e1", spike_out, 4'b0000);
    tick(); chk("lat_e2", spike_out, 4'b0000);
    tick(); chk("lat_e3", spike_out, 4'b0001);
    chk("lat_pot", pot_east, 8'd0);
    tick(); chk("hi_2", spike_out, 4'b0001);
    tick(); chk("lo_1", spike_out, 4'b0000);
    tick(); chk("lo_2", spike_out, 4'b0000);
    tick(); chk("lo_3", spike_out, 4'b0000);
    chk("east_after", pot_east, 8'd0);

    // threshold 4, backward Y steps
    cfg_threshold = 8'd4;
    for (int i = 0; i < 3; i++) begin
      y_step(0);
      ticks(3);
    end
    chk("south_3", pot_south, 8'd3);
    chk("south_nospk", spike_out, 4'b0000);
    y_step(0);
    ticks(2);
    chk("south_pre", spike_out, 4'b0000);
    tick();
    chk("south_fire", spike_out, 4'b1000);
    chk("south_zero", pot_south, 8'd0);
    ticks(5);

    // leak: 3 east steps then period 5
    cfg_threshold = 8'd10;
    for (int i = 0; i < 3; i++) begin
      x_step(1);
      ticks(3);
    end
    chk("leak_start", pot_east, 8'd3);
    cfg_leak_period = 8'd5;
    ticks(4); chk("leak_4", pot_east, 8'd3);
    tick();   chk("leak_5", pot_east, 8'd2);
    ticks(4); chk("leak_9", pot_east, 8'd2);
    tick();   chk("leak_10", pot_east, 8'd1);
    ticks(5); chk("leak_15", pot_east, 8'd0);
    ticks(5); chk("leak_hold", pot_east, 8'd0);
    chk("leak_nospk", spike_out, 4'b0000);
    cfg_leak_period = 8'd0;

    // illegal X transition 00 -> 11
    {enc_x_a, enc_x_b} = 2'b11;
    xpos = 2'd2;
    ticks(2); chk("ill_pre", enc_error, 1'b0);
    tick();   chk("ill_set", enc_error, 1'b1);
    chk("ill_nostep", {pot_east, pot_west}, 16'd0);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ill_clr", enc_error, 1'b0);
    {enc_x_a, enc_x_b} = 2'b00;
    xpos = 2'd0;
    ticks(2);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ill_wins", enc_error, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ill_clr2", enc_error, 1'b0);

    // continuous north steps at threshold 1
    cfg_threshold = 8'd1;
    prev_s = 1'b0;
    seen = 1'b0;
    hi = 0;
    lo = 0;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      if (i < 20) y_step(1);
      tick();
      s = spike_out[1];
      if (s && !prev_s) begin
        if (seen) chk("gap_len", lo >= 2, 1'b1);
        pulses++;
        seen = 1'b1;
        hi = 1;
      end else if (s) begin
        hi++;
      end else if (prev_s) begin
        chk("hi_len", hi, 32'd2);
        lo = 1;
      end else begin
        lo++;
      end
      prev_s = s;
    end
    chk("pulses", pulses >= 4, 1'b1);
    ticks(5);
    chk("burst_pot", pot_north, 8'd0);
    chk("burst_idle", spike_out, 4'b0000);

    // enable gating
    cfg_threshold = 8'd10;
    for (int i = 0; i < 5; i++) begin
      y_step(1);
      ticks(3);
    end
    chk("north_5", pot_north, 8'd5);
    cfg_enable = 1'b0;
    tick();
    chk("dis_clr", pot_north, 8'd0);
    for (int i = 0; i < 3; i++) begin
      y_step(1);
      tick();
    end
    ticks(3);
    chk("dis_pot", pot_north, 8'd0);
    chk("dis_spk", spike_out, 4'b0000);
    cfg_enable = 1'b1;
    cfg_threshold = 8'd1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("reen_spk", spike_out, 4'b0000);
    end
    chk("reen_pot", pot_north, 8'd0);

    // async reset mid-pulse
    x_step(1);
    ticks(3);
    chk("mid_hi", spike_out, 4'b0001);
    #2 rst_n = 1'b0;
    #1 chk("mid_rst", spike_out, 4'b0000);
    #10 rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/quad_spike_encoder.md
Name: quad_spike_encoder

Overview:
- Upstream front-end for the neuro-nav SLAM peripheral.
- Converts two quadrature wheel encoders (X axis, Y axis) into four leaky integrate-and-fire spike trains, ordered {south, west, north, east}.
- spike_out drives the peripheral's ui_in[3:0] directly.
- Every spike is a clean high pulse followed by a guaranteed low gap, so the downstream rising-edge detector never misses or merges spikes.

Parameters:
- PULSE_LEN, 2: cycles spike_out[d] stays high per spike (min 1).
- REFRACT_LEN, 2: cycles spike_out[d] is forced low after each pulse (min 1).
- POT_W, 8: membrane potential width per direction.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enc_x_a, enc_x_b  in  1 each  X-axis quadrature inputs, asynchronous to clk.
- enc_y_a, enc_y_b  in  1 each  Y-axis quadrature inputs, asynchronous to clk.
- cfg_enable  in  1  enables integration.
- cfg_threshold  in  POT_W  fire threshold; 0 is treated as 1.
- cfg_leak_period  in  8  leak period in cycles; 0 disables leak.
- err_clr  in  1  single-cycle clear of enc_error.
- spike_out  out  4  {south, west, north, east} spike lines.
- enc_error  out  1  sticky flag: illegal quadrature transition seen.
- pot_east, pot_north, pot_west, pot_south  out  POT_W each  current potentials, for debug readback.

Behaviour:
- Reset (async, rst_n low):
  - All potentials 0; spike_out 4'b0000; enc_error 0; leak counter 0; all channel FSMs IDLE.
  - Synchronizer and previous-state registers reset to 2'b00.
  - Reset mid-pulse drops spike_out low immediately.
- Synchronization: each enc input passes through a 2-flop synchronizer. Decode compares the current synced {a,b} against the previous synced {a,b}.
- Decode, per axis:
  - 00→01→11→10→00 is a forward step: east for X, north for Y.
  - The reverse sequence is a backward step: west for X, south for Y.
  - No change means no step.
  - Both bits changing at once is illegal: no step, and enc_error is set.
  - err_clr clears enc_error; an illegal transition in the same cycle wins (flag stays 1).
  - The previous-state register always updates, even when cfg_enable=0, so re-enabling never produces a phantom step.
- Integration, per direction d, each cycle:
  - p1 = min(pot + inc_d, 2^POT_W − 1).
  - p2 = leak_tick ? max(p1 − 1, 0) : p1.
  - A step and a leak in the same cycle net to no change; from 0 the result stays 0.
- Leak counter:
  - Increments every cycle while cfg_leak_period≠0.
  - At count == cfg_leak_period−1, leak_tick pulses for one cycle and the counter returns to 0.
  - With cfg_leak_period=0 the counter holds 0 and no leak occurs.
  - A period change takes effect on the next compare.
- Firing:
  - If channel d is IDLE and p2 ≥ max(cfg_threshold, 1), the channel fires: pot_d ← 0 and the FSM goes to HIGH.
  - Otherwise pot_d ← p2.
  - While a channel is in HIGH or REFRACT, its potential keeps integrating (saturating). It fires on the first IDLE cycle that meets threshold.
- Channel FSM, per direction:
  - IDLE→HIGH on fire.
  - HIGH lasts exactly PULSE_LEN cycles, then →REFRACT.
  - REFRACT lasts exactly REFRACT_LEN cycles, then →IDLE.
  - spike_out[d] is a registered output, high only in HIGH.
  - Maximum spike rate per line is 1/(PULSE_LEN+REFRACT_LEN+1).
- Latency: counting the clk edge that first samples a new encoder level as edge 1, spike_out[d] rises after edge 3 (sync1, sync2, fire), given threshold 1 and an IDLE channel.
- cfg_enable=0:
  - inc_d is forced to 0 and leak is suspended.
  - All potentials clear to 0 on the next cycle.
  - An in-flight HIGH/REFRACT sequence completes normally.
- Independence: all four channels are independent; simultaneous X and Y steps update both. East and west cannot step in the same cycle.

Test Plan:
- Reset with enc lines held 00, then one forward X step (00→01) at threshold=1 → spike_out=4'b0001 rises 3 edges after sampling, stays high 2 cycles, then low ≥2 cycles; pot_east=0 afterwards.
- Threshold=4, leak off, 3 backward Y steps → pot_south=3 and no spike; a 4th step → spike_out[3] pulses and pot_south returns to 0.
- Threshold=10, leak_period=5, 3 east steps then idle → pot_east decrements every 5 cycles (3→2→1→0) and holds at 0; no spike.
- Illegal transition on X (00→11) → no step and enc_error=1; err_clr pulse → enc_error=0; err_clr coinciding with a new illegal transition → enc_error stays 1.
- Threshold=1 with steps arriving every cycle during HIGH/REFRACT → no merged pulses; the low gap between consecutive pulses is always ≥ REFRACT_LEN cycles; the accumulated potential fires on return to IDLE.
- cfg_enable=0 with pot_north=5 → pot_north=0 the next cycle; encoder toggles produce no steps; re-enable → no spurious spike.
